// File: rtl/stream_xbar_arb.sv
// Control side of the stream crossbar: per-output round-robin arbitration with
// packet-long grant locking, one-hot source selects and per-source ready.
module stream_xbar_arb #(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [M_DATA_COUNT*S_DATA_COUNT-1:0] req_o,
    output logic [M_DATA_COUNT-1:0]              busy_o
);

    localparam int PTR_W = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]              state   [M_DATA_COUNT];
    logic [PTR_W-1:0]        gidx    [M_DATA_COUNT];
    logic [PTR_W-1:0]        ptr     [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] req_m   [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] grant   [M_DATA_COUNT];

    // First requester found scanning from the pointer, wrapping modulo S.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [S_DATA_COUNT-1:0] r,
                                                 input logic [PTR_W-1:0]        p);
        logic [PTR_W-1:0] sel;
        logic             found;
        int               k;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            k = (int'(p) + i) % S_DATA_COUNT;
            if (!found && r[k]) begin
                sel   = PTR_W'(k);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] s);
        return PTR_W'((int'(s) + 1) % S_DATA_COUNT);
    endfunction

    // Out-of-range destinations never compare equal to a valid output index.
    always_comb begin
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                req_m[m][s] = s_valid_i[s] &&
                              (s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(m));
            end
        end
    end

    always_comb begin
        logic [S_DATA_COUNT-1:0] rdy;
        rdy = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            grant[m] = '0;
            if (state[m] == ST_LOCKED) begin
                grant[m][gidx[m]] = 1'b1;
            end
            req_o[m*S_DATA_COUNT +: S_DATA_COUNT] = grant[m];
            busy_o[m] = (state[m] == ST_LOCKED);
            rdy = rdy | (grant[m] & {S_DATA_COUNT{m_ready_i[m]}});
        end
        s_ready_o = rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                state[m] <= ST_IDLE;
                gidx[m]  <= '0;
                ptr[m]   <= '0;
            end
        end else begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                case (state[m])
                    ST_IDLE: begin
                        if (|req_m[m]) begin
                            gidx[m]  <= rr_pick(req_m[m], ptr[m]);
                            state[m] <= ST_LOCKED;
                        end
                    end
                    default: begin
                        // Grant is held until the granted source's last beat is accepted.
                        if (s_valid_i[gidx[m]] && s_ready_o[gidx[m]] && s_last_i[gidx[m]]) begin
                            state[m] <= ST_IDLE;
                            ptr[m]   <= ptr_after(gidx[m]);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_xbar_arb.sv
// Bench for stream_xbar_arb: directed scenarios plus randomized traffic
// checked against a per-output owner/pointer reference model.
module tb_stream_xbar_arb;

    localparam int S = 2;
    localparam int M = 3;
    localparam int T = 2;

    logic             clk;
    logic             rst_n;
    logic [S*T-1:0]   s_dest;
    logic [S-1:0]     s_valid;
    logic [S-1:0]     s_last;
    logic [S-1:0]     s_ready;
    logic [M-1:0]     m_ready;
    logic [M*S-1:0]   req;
    logic [M-1:0]     busy;

    int n_cmp;
    int n_bad;

    // Reference model: which source owns each output, and the RR start point.
    bit mlock [M];
    int mown  [M];
    int mptr  [M];

    stream_xbar_arb #(.S_DATA_COUNT(S), .M_DATA_COUNT(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_dest_i  (s_dest),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .m_ready_i (m_ready),
        .req_o     (req),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dest_of(int s);
        return int'(s_dest[s*T +: T]);
    endfunction

    function automatic logic [M*S-1:0] exp_req();
        logic [M*S-1:0] r;
        r = '0;
        for (int m = 0; m < M; m++) if (mlock[m]) r[m*S + mown[m]] = 1'b1;
        return r;
    endfunction

    function automatic logic [M-1:0] exp_busy();
        logic [M-1:0] b;
        for (int m = 0; m < M; m++) b[m] = mlock[m];
        return b;
    endfunction

    function automatic logic [S-1:0] exp_ready();
        logic [S-1:0] r;
        r = '0;
        for (int m = 0; m < M; m++) if (mlock[m] && m_ready[m]) r[mown[m]] = 1'b1;
        return r;
    endfunction

    function automatic bit src_owned(int s);
        for (int m = 0; m < M; m++) if (mlock[m] && mown[m] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            mlock[m] = 1'b0;
            mown[m]  = 0;
            mptr[m]  = 0;
        end
    endtask

    task automatic model_update();
        logic [S-1:0] rdy;
        int           s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = exp_ready();
        for (int m = 0; m < M; m++) begin
            if (mlock[m]) begin
                s = mown[m];
                if (s_valid[s] && rdy[s] && s_last[s]) begin
                    mlock[m] = 1'b0;
                    mptr[m]  = (s + 1) % S;
                end
            end else begin
                for (int i = 0; i < S; i++) begin
                    s = (mptr[m] + i) % S;
                    if (!mlock[m] && s_valid[s] && dest_of(s) == m) begin
                        mlock[m] = 1'b1;
                        mown[m]  = s;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_dest  = '0;
        s_valid = '0;
        s_last  = '0;
        m_ready = '1;
        model_reset();
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (req !== '0) begin n_bad++; $display("FAIL reset_req got=%b want=0", req); end
        n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (s_ready !== '0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", s_ready); end
    endtask

    task automatic test_single_dest();
        do_reset();
        s_dest[0 +: T] = 2'd1;
        s_valid = 2'b01;
        #1;
        n_cmp++; if (req !== '0) begin n_bad++; $display("FAIL t1_idle_req got=%b want=0", req); end
        cyc();
        for (int b = 1; b <= 3; b++) begin
            s_last = (b == 3) ? 2'b01 : 2'b00;
            #1;
            n_cmp++; if (req !== 6'b00_01_00) begin n_bad++; $display("FAIL t1_req_beat%0d got=%b want=000100", b, req); end
            n_cmp++; if (s_ready[0] !== 1'b1) begin n_bad++; $display("FAIL t1_ready_beat%0d got=%b want=1", b, s_ready[0]); end
            cyc();
        end
        s_valid = '0;
        s_last  = '0;
        #1;
        n_cmp++; if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after got=%b want=0", busy[1]); end
        n_cmp++; if (req !== '0) begin n_bad++; $display("FAIL t1_req_after got=%b want=0", req); end
    endtask

    task automatic test_rr_tie();
        do_reset();
        s_dest  = {2'd2, 2'd2};
        s_valid = 2'b11;
        s_last  = 2'b11;
        cyc();
        #1;
        n_cmp++; if (req[5:4] !== 2'b01) begin n_bad++; $display("FAIL t2_first got=%b want=01", req[5:4]); end
        n_cmp++; if (s_ready !== 2'b01) begin n_bad++; $display("FAIL t2_first_ready got=%b want=01", s_ready); end
        cyc();
        #1;
        n_cmp++; if (busy[2] !== 1'b0) begin n_bad++; $display("FAIL t2_bubble got=%b want=0", busy[2]); end
        cyc();
        #1;
        n_cmp++; if (req[5:4] !== 2'b10) begin n_bad++; $display("FAIL t2_tie_s1 got=%b want=10", req[5:4]); end
        cyc();
        cyc();
        #1;
        n_cmp++; if (req[5:4] !== 2'b01) begin n_bad++; $display("FAIL t2_back_s0 got=%b want=01", req[5:4]); end
        s_valid = '0;
        cyc();
        cyc();
    endtask

    task automatic test_parallel();
        do_reset();
        s_dest  = {2'd2, 2'd0};
        s_valid = 2'b11;
        cyc();
        #1;
        n_cmp++; if (req !== 6'b10_00_01) begin n_bad++; $display("FAIL t3_req got=%b want=100001", req); end
        n_cmp++; if (busy !== 3'b101) begin n_bad++; $display("FAIL t3_busy got=%b want=101", busy); end
        n_cmp++; if (s_ready !== 2'b11) begin n_bad++; $display("FAIL t3_ready got=%b want=11", s_ready); end
        s_last = 2'b11;
        cyc();
        s_valid = '0;
        s_last  = '0;
        #1;
        n_cmp++; if (busy !== 3'b000) begin n_bad++; $display("FAIL t3_release got=%b want=000", busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        s_dest[0 +: T] = 2'd1;
        s_valid = 2'b01;
        cyc();
        m_ready = 3'b101;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (s_ready[0] !== 1'b0) begin n_bad++; $display("FAIL t4_stall_ready%0d got=%b want=0", c, s_ready[0]); end
            n_cmp++; if (busy !== 3'b010) begin n_bad++; $display("FAIL t4_stall_busy%0d got=%b want=010", c, busy); end
            n_cmp++; if (req[3:2] !== 2'b01) begin n_bad++; $display("FAIL t4_stall_req%0d got=%b want=01", c, req[3:2]); end
            s_last = 2'b01;
            cyc();
        end
        m_ready = 3'b111;
        #1;
        n_cmp++; if (s_ready[0] !== 1'b1) begin n_bad++; $display("FAIL t4_resume got=%b want=1", s_ready[0]); end
        cyc();
        s_valid = '0;
        s_last  = '0;
        #1;
        n_cmp++; if (busy !== 3'b000) begin n_bad++; $display("FAIL t4_done got=%b want=000", busy); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        s_dest  = {2'd0, 2'd0};
        s_valid = 2'b01;
        s_last  = 2'b01;
        cyc();
        cyc();
        s_valid = 2'b10;
        s_last  = 2'b00;
        cyc();
        #1;
        n_cmp++; if (req[1:0] !== 2'b10) begin n_bad++; $display("FAIL t5_pre got=%b want=10", req[1:0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req !== '0) begin n_bad++; $display("FAIL t5_async_req got=%b want=0", req); end
        n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL t5_async_busy got=%b want=0", busy); end
        n_cmp++; if (s_ready !== '0) begin n_bad++; $display("FAIL t5_async_ready got=%b want=0", s_ready); end
        cyc();
        rst_n   = 1'b1;
        s_valid = 2'b11;
        cyc();
        #1;
        n_cmp++; if (req[1:0] !== 2'b01) begin n_bad++; $display("FAIL t5_ptr0 got=%b want=01", req[1:0]); end
        s_valid = '0;
        cyc();
    endtask

    task automatic test_bad_dest();
        do_reset();
        s_dest[T +: T] = 2'd3;
        s_valid = 2'b10;
        for (int c = 0; c < 10; c++) begin
            cyc();
            #1;
            n_cmp++; if (req !== '0 || s_ready[1] !== 1'b0) begin
                n_bad++; $display("FAIL t6_bad_dest%0d req=%b ready=%b want req=0 ready=0", c, req, s_ready[1]);
            end
        end
        s_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < S; s++) begin
                if (!src_owned(s) && $urandom_range(0, 3) == 0) s_dest[s*T +: T] = T'($urandom_range(0, 3));
                s_valid[s] = ($urandom_range(0, 3) != 0);
                s_last[s]  = ($urandom_range(0, 2) == 0);
            end
            m_ready = M'($urandom);
            #1;
            n_cmp++; if (req !== exp_req()) begin n_bad++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, req, exp_req()); end
            n_cmp++; if (busy !== exp_busy()) begin n_bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, exp_busy()); end
            n_cmp++; if (s_ready !== exp_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, s_ready, exp_ready()); end
            cyc();
        end
        s_valid = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_dest();
        test_rr_tie();
        test_parallel();
        test_backpressure();
        test_reset_mid_packet();
        test_bad_dest();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
